e_mdu: RTL and testbench

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It holds the architectural HI/LO registers and executes mult/multu/div/divu as fixed-latency multi-cycle operations behind a Busy flag. It also services mthi/mtlo writes and supplies the mfhi/mflo read value, MDdata_E, which travels down the pipeline registers to the W-stage result select.

---
 rtl/e_mdu.sv | 189 ++++++++++++++++++
 tb/tb_e_mdu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: architectural HI/LO plus fixed-latency mult/div behind Busy_E.
// Optional accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_E,
    input  logic [3:0]  MDOp_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    output logic        Busy_E,
    output logic [31:0] MDdata_E,
    output logic [31:0] HI_o,
    output logic [31:0] LO_o
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_pend_q, hi_pend_d;
    logic [31:0]      lo_pend_q, lo_pend_d;
    logic             wr_pend_q, wr_pend_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, div_s_den, div_u_den;
    logic [31:0] q_s_mag, r_s_mag, q_s, r_s, q_u, r_u;
`ifdef MDU_MADD_EN
    logic [63:0] acc;
`endif

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        prod_u = {32'b0, A_E} * {32'b0, B_E};
        prod_s = {{32{A_E[31]}}, A_E} * {{32{B_E[31]}}, B_E};
`ifdef MDU_MADD_EN
        acc    = {hi_q, lo_q};
`endif
    end

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    always_comb begin
        a_mag     = A_E[31] ? (~A_E + 32'd1) : A_E;
        b_mag     = B_E[31] ? (~B_E + 32'd1) : B_E;
        div_s_den = (b_mag == '0) ? 32'd1 : b_mag;
        div_u_den = (B_E == '0) ? 32'd1 : B_E;
        q_s_mag   = a_mag / div_s_den;
        r_s_mag   = a_mag % div_s_den;
        q_s       = (A_E[31] ^ B_E[31]) ? (~q_s_mag + 32'd1) : q_s_mag;
        r_s       = A_E[31] ? (~r_s_mag + 32'd1) : r_s_mag;
        q_u       = A_E / div_u_den;
        r_u       = A_E % div_u_den;
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        wr_pend_d = wr_pend_q;

        if (state_q == S_IDLE) begin
            if (Start_E) begin
                case (MDOp_E)
                    OP_MULT: begin
                        {hi_pend_d, lo_pend_d} = prod_s;
                        wr_pend_d              = 1'b1;
                        cnt_d                  = CNT_W'(MULT_CYCLES);
                    end
                    OP_MULTU: begin
                        {hi_pend_d, lo_pend_d} = prod_u;
                        wr_pend_d              = 1'b1;
                        cnt_d                  = CNT_W'(MULT_CYCLES);
                    end
                    OP_DIV: begin
                        hi_pend_d = r_s;
                        lo_pend_d = q_s;
                        wr_pend_d = (B_E != '0);
                        cnt_d     = CNT_W'(DIV_CYCLES);
                    end
                    OP_DIVU: begin
                        hi_pend_d = r_u;
                        lo_pend_d = q_u;
                        wr_pend_d = (B_E != '0);
                        cnt_d     = CNT_W'(DIV_CYCLES);
                    end
`ifdef MDU_MADD_EN
                    OP_MADD: begin
                        {hi_pend_d, lo_pend_d} = acc + prod_s;
                        wr_pend_d              = 1'b1;
                        cnt_d                  = CNT_W'(MULT_CYCLES);
                    end
                    OP_MADDU: begin
                        {hi_pend_d, lo_pend_d} = acc + prod_u;
                        wr_pend_d              = 1'b1;
                        cnt_d                  = CNT_W'(MULT_CYCLES);
                    end
                    OP_MSUB: begin
                        {hi_pend_d, lo_pend_d} = acc - prod_s;
                        wr_pend_d              = 1'b1;
                        cnt_d                  = CNT_W'(MULT_CYCLES);
                    end
                    OP_MSUBU: begin
                        {hi_pend_d, lo_pend_d} = acc - prod_u;
                        wr_pend_d              = 1'b1;
                        cnt_d                  = CNT_W'(MULT_CYCLES);
                    end
`endif
                    default: ;
                endcase
            end
            if (MDOp_E == OP_MTHI) hi_d = A_E;
            if (MDOp_E == OP_MTLO) lo_d = A_E;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && wr_pend_q) begin
                hi_d = hi_pend_q;
                lo_d = lo_pend_q;
            end
        end
    end

    always_comb begin
        busy_d  = (cnt_d != '0);
        state_d = busy_d ? S_RUN : S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            hi_pend_q <= '0;
            lo_pend_q <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    always_comb begin
        case (MDOp_E)
            OP_MFHI: MDdata_E = hi_q;
            OP_MFLO: MDdata_E = lo_q;
            default: MDdata_E = '0;
        endcase
    end

    assign Busy_E = busy_q;
    assign HI_o   = hi_q;
    assign LO_o   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: vector table with a result scoreboard plus hand-written corner sequences.
module tb_e_mdu;
    logic        clk;
    logic        rst_n;
    logic        Start_E;
    logic [3:0]  MDOp_E;
    logic [31:0] A_E, B_E;
    logic        Busy_E;
    logic [31:0] MDdata_E, HI_o, LO_o;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [31:0] pre_hi, pre_lo;
        logic [31:0] exp_hi, exp_lo;
        int          cycles;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi, lo, pre_hi, pre_lo;
        int          cycles;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .Start_E  (Start_E),
        .MDOp_E   (MDOp_E),
        .A_E      (A_E),
        .B_E      (B_E),
        .Busy_E   (Busy_E),
        .MDdata_E (MDdata_E),
        .HI_o     (HI_o),
        .LO_o     (LO_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic preset(input logic [31:0] hi, input logic [31:0] lo);
        Start_E = 1'b0;
        MDOp_E = 4'd7; A_E = hi; tick;
        MDOp_E = 4'd8; A_E = lo; tick;
        MDOp_E = 4'd0; A_E = '0;
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDOp_E = op; A_E = a; B_E = b; Start_E = 1'b1;
        tick;
        Start_E = 1'b0; MDOp_E = 4'd0;
    endtask

    // Counts busy cycles (bounded) and flags any HI/LO change before completion.
    task automatic wait_idle(input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                             output int n, output logic hold_ok);
        n = 0; hold_ok = 1'b1;
        while (Busy_E && n < 64) begin
            if (HI_o !== pre_hi || LO_o !== pre_lo) hold_ok = 1'b0;
            n++;
            tick;
        end
    endtask

    task automatic score(input int n, input logic hold_ok);
        exp_t e;
        e = sb.pop_front();
        check({e.name, " busy_cycles"}, 32'(n), 32'(e.cycles));
        check({e.name, " hold"}, {31'b0, hold_ok}, 32'd1);
        check({e.name, " HI"}, HI_o, e.hi);
        check({e.name, " LO"}, LO_o, e.lo);
        MDOp_E = 4'd5; #1;
        check({e.name, " mfhi"}, MDdata_E, e.hi);
        MDOp_E = 4'd6; #1;
        check({e.name, " mflo"}, MDdata_E, e.lo);
        MDOp_E = 4'd0;
    endtask

    initial begin
        int          n;
        logic        hold_ok;

        vecs[0]  = '{"mult_neg",  4'd1, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{"multu",     4'd2, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{"mult_max",  4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[3]  = '{"multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[4]  = '{"div_m7_2",  4'd3, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5]  = '{"div_7_m2",  4'd3, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[6]  = '{"div_ovf",   4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h00000000, 32'h80000000, 10};
        vecs[7]  = '{"divu",      4'd4, 32'd100, 32'd7, 32'h0, 32'h0, 32'h00000002, 32'h0000000E, 10};
        vecs[8]  = '{"divu_zero", 4'd4, 32'd9, 32'd0, 32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};
        vecs[9]  = '{"div_zero",  4'd3, 32'hFFFFFFF0, 32'd0, 32'hAA, 32'hBB, 32'h000000AA, 32'h000000BB, 10};
`ifdef MDU_MADD_EN
        vecs[10] = '{"maddu",     4'd10, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5};
`else
        vecs[10] = '{"maddu_off", 4'd10, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0};
`endif

        rst_n = 1'b0; Start_E = 1'b0; MDOp_E = 4'd0; A_E = '0; B_E = '0;
        tick; tick;
        check("rst busy", {31'b0, Busy_E}, 32'd0);
        check("rst HI", HI_o, 32'd0);
        check("rst LO", LO_o, 32'd0);
        MDOp_E = 4'd5; #1;
        check("rst mfhi", MDdata_E, 32'd0);
        MDOp_E = 4'd0;
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 11; i++) begin
            preset(vecs[i].pre_hi, vecs[i].pre_lo);
            sb.push_back('{vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo,
                           vecs[i].pre_hi, vecs[i].pre_lo, vecs[i].cycles});
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(vecs[i].pre_hi, vecs[i].pre_lo, n, hold_ok);
            score(n, hold_ok);
        end

        // mthi/mtlo in IDLE visible the following cycle
        MDOp_E = 4'd7; A_E = 32'h1234; tick;
        MDOp_E = 4'd5; #1;
        check("mthi mfhi", MDdata_E, 32'h1234);
        MDOp_E = 4'd8; A_E = 32'h5678; tick;
        MDOp_E = 4'd6; #1;
        check("mtlo mflo", MDdata_E, 32'h5678);
        MDOp_E = 4'd0;

        // mtlo issued during RUN is dropped
        preset(32'h0, 32'h0);
        sb.push_back('{"mtlo_in_run", 32'h0, 32'hF, 32'h0, 32'h0, 5});
        launch(4'd1, 32'd3, 32'd5);
        tick;
        MDOp_E = 4'd8; A_E = 32'hDEAD; tick;
        MDOp_E = 4'd0; A_E = '0;
        wait_idle(32'h0, 32'h0, n, hold_ok);
        score(n + 2, hold_ok);

        // Start during RUN is ignored and does not stretch Busy
        preset(32'h0, 32'h0);
        sb.push_back('{"start_in_run", 32'd2, 32'd14, 32'h0, 32'h0, 10});
        launch(4'd4, 32'd100, 32'd7);
        n = 0; hold_ok = 1'b1;
        while (Busy_E && n < 64) begin
            Start_E = (n == 2);
            MDOp_E  = (n == 2) ? 4'd1 : 4'd0;
            A_E = 32'd2; B_E = 32'd2;
            if (HI_o !== 32'h0 || LO_o !== 32'h0) hold_ok = 1'b0;
            n++;
            tick;
        end
        Start_E = 1'b0; MDOp_E = 4'd0;
        score(n, hold_ok);
        tick; tick; tick;
        check("start_in_run no_rebusy", {31'b0, Busy_E}, 32'd0);
        check("start_in_run LO_kept", LO_o, 32'd14);

        // Asynchronous reset mid-operation aborts and discards the result
        preset(32'h55, 32'h66);
        launch(4'd1, 32'd3, 32'd5);
        tick;
        rst_n = 1'b0; #1;
        check("midrst busy", {31'b0, Busy_E}, 32'd0);
        check("midrst HI", HI_o, 32'd0);
        check("midrst LO", LO_o, 32'd0);
        rst_n = 1'b1;
        repeat (8) tick;
        check("postrst busy", {31'b0, Busy_E}, 32'd0);
        check("postrst HI", HI_o, 32'd0);
        check("postrst LO", LO_o, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
